pipeline_run_controller: RTL

- Sequences the five-stage pipeline (IF/ID/EX/MEM/WB), including the Execute stage, under host or debug-unit command.
- Generates the global stage enable and the PC enable, and supports continuous run, single-step and pause.
- On a decoded HALT instruction it drains the in-flight instructions to write-back, then parks in a terminal state.
- Also maintains a saturating count of enabled cycles for the debug unit.

---
 rtl/pipeline_run_controller_pkg.sv | 21 ++
 rtl/pipeline_run_controller_if.sv | 9 +
 rtl/pipeline_run_controller_sat_counter.sv | 33 +++
 rtl/pipeline_run_controller.sv | 102 ++++++++++
 4 files changed

// File: rtl/pipeline_run_controller_pkg.sv
// rtl/pipeline_run_controller_pkg.sv - shared state encodings and command opcodes for the run controller
package pipe_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_PAUSE = 2'b11
  } cmd_e;

endpackage

// File: rtl/pipeline_run_controller_if.sv
// rtl/pipeline_run_controller_if.sv - host/debug command handshake bundle
interface pipeline_run_controller_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/pipeline_run_controller_sat_counter.sv
// rtl/pipeline_run_controller_sat_counter.sv - saturating up-counter with async active-low clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Increment when enabled, holding at all-ones instead of wrapping
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_run_controller.sv
// rtl/pipeline_run_controller.sv - run/step/pause/halt-drain sequencer for the five-stage pipeline
module pipeline_run_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  pipeline_run_controller_if.slave   cmd,
  input  logic                       halt_detect,
  input  logic                       stall_req,
  output logic                       pipe_en,
  output logic                       pc_en,
  output logic                       busy,
  output logic                       done,
  output logic [STATE_W-1:0]         state_o,
  output logic [CNT_W-1:0]           cycle_count
);

  // Counter is loaded with one less than the drain length; the edge that
  // sees zero is the last enabled one and moves to DONE.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic       cmd_fire;

  assign cmd_fire = cmd.cmd_valid && cmd.cmd_ready;

  // Next-state and drain counter decode
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire && (cmd.cmd_op == CMD_RUN)) begin
          state_d = ST_RUN;
        end else if (cmd_fire && (cmd.cmd_op == CMD_STEP)) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        // HALT beats a coincident PAUSE so in-flight work always drains
        if (halt_detect) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end else if (cmd_fire && (cmd.cmd_op == CMD_PAUSE)) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_detect) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d     = ST_IDLE;
        drain_cnt_d = 4'd0;
      end
    endcase
  end

  // State register; reset aborts any drain in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign pipe_en       = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
  assign busy          = pipe_en;
  assign done          = (state_q == ST_DONE);
  assign state_o       = state_q;
  assign cmd.cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_DONE);
  assign pc_en         = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !stall_req;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (pipe_en),
    .count_o (cycle_count)
  );

endmodule
